// File: rtl/spi_tx_arbiter.sv
// Round-robin scheduler sharing one SPI_TX master among four requesters.
// Each frame is timed by a fixed window followed by a CS guard gap.
module spi_tx_arbiter #(
    parameter int START_HOLD   = 4,
    parameter int FRAME_CYCLES = 16500,
    parameter int GAP_CYCLES   = 16,
    parameter int CNT_W        = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [3:0]  req,
    input  logic [39:0] req_data,
    output logic [3:0]  ack,
    output logic [3:0]  done,
    output logic        busy,
    output logic        start_transmit,
    output logic [2:0]  selector_cs,
    output logic [9:0]  data
);

    localparam logic [CNT_W-1:0] HOLD_END  = CNT_W'(START_HOLD);
    localparam logic [CNT_W-1:0] FRAME_END = CNT_W'(FRAME_CYCLES);
    localparam logic [CNT_W-1:0] GAP_END   = CNT_W'(FRAME_CYCLES + GAP_CYCLES);
    localparam logic [2:0]       NO_CS     = 3'd7;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        GAP,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [3:0]       ack_d, done_d;
    logic             busy_d, start_d;
    logic [2:0]       sel_d;
    logic [9:0]       data_d;
    logic [3:0][9:0]  words;
    logic [1:0]       win;
    logic             win_vld;
    logic             grant;

    assign words = req_data;

    // Pick the first requester after the last grant, wrapping mod 4.
    always_comb begin
        logic [1:0] idx;
        win     = 2'd0;
        win_vld = 1'b0;
        idx     = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            idx = ptr_q + 2'(i);
            if (!win_vld && req[idx]) begin
                win     = idx;
                win_vld = 1'b1;
            end
        end
    end

    // DONE behaves like IDLE so back-to-back frames lose no extra cycle.
    assign grant = (state_q == IDLE || state_q == DONE) && enable && win_vld;

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q + 1'b1;
        ptr_d   = ptr_q;
        ack_d   = 4'd0;
        done_d  = 4'd0;
        busy_d  = busy;
        start_d = start_transmit;
        sel_d   = selector_cs;
        data_d  = data;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                timer_d = '0;
                busy_d  = 1'b0;
                start_d = 1'b0;
                sel_d   = NO_CS;
                if (grant) begin
                    state_d    = START;
                    timer_d    = CNT_W'(1);
                    ptr_d      = win;
                    ack_d[win] = 1'b1;
                    busy_d     = 1'b1;
                    start_d    = 1'b1;
                    sel_d      = {1'b0, win};
                    data_d     = words[win];
                end
            end
            START: begin
                if (timer_q == HOLD_END) begin
                    state_d = WAIT;
                    start_d = 1'b0;
                end
            end
            WAIT: begin
                if (timer_q == FRAME_END) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                if (timer_q == GAP_END) begin
                    state_d       = DONE;
                    done_d[ptr_q] = 1'b1;
                    busy_d        = 1'b0;
                    sel_d         = NO_CS;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, timer and registered outputs; reset aborts any frame silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            timer_q        <= '0;
            ptr_q          <= 2'd3;
            ack            <= 4'd0;
            done           <= 4'd0;
            busy           <= 1'b0;
            start_transmit <= 1'b0;
            selector_cs    <= NO_CS;
            data           <= 10'd0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            ptr_q          <= ptr_d;
            ack            <= ack_d;
            done           <= done_d;
            busy           <= busy_d;
            start_transmit <= start_d;
            selector_cs    <= sel_d;
            data           <= data_d;
        end
    end

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Directed bench for spi_tx_arbiter with shortened frame timing.
// Table-driven single grants plus multi-cycle corner sequences.
module tb_spi_tx_arbiter;

    localparam int H = 4;
    localparam int F = 40;
    localparam int G = 6;
    localparam int P = F + G + 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [3:0]  req;
    logic [39:0] req_data;
    logic [3:0]  ack;
    logic [3:0]  done;
    logic        busy;
    logic        start_transmit;
    logic [2:0]  selector_cs;
    logic [9:0]  data;

    int checks = 0;
    int errors = 0;

    localparam logic [39:0] STD = {10'h3C3, 10'h155, 10'h0AA, 10'h1F0};

    typedef struct {
        logic [3:0]  req;
        logic [39:0] rdata;
        int          exp_ch;
        logic [9:0]  exp_data;
    } vec_t;

    vec_t vecs [6];

    spi_tx_arbiter #(
        .START_HOLD(H),
        .FRAME_CYCLES(F),
        .GAP_CYCLES(G),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .req(req),
        .req_data(req_data),
        .ack(ack),
        .done(done),
        .busy(busy),
        .start_transmit(start_transmit),
        .selector_cs(selector_cs),
        .data(data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int oh2i(input logic [3:0] v);
        case (v)
            4'b0001: return 0;
            4'b0010: return 1;
            4'b0100: return 2;
            4'b1000: return 3;
            default: return -1;
        endcase
    endfunction

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic wait_ack(output int ch, output int waited);
        ch = -2;
        waited = 0;
        for (int i = 1; i <= 2 * P; i++) begin
            @(negedge clk);
            if (ack != 4'd0) begin
                ch = oh2i(ack);
                waited = i;
                return;
            end
        end
    endtask

    task automatic wait_done(output int ch);
        ch = -2;
        for (int i = 0; i < 2 * P; i++) begin
            @(negedge clk);
            if (done != 4'd0) begin
                ch = oh2i(done);
                return;
            end
        end
    endtask

    // Starts at the negedge of cycle 1; ends at the negedge of the DONE cycle.
    task automatic run_frame(input int ch, input logic [9:0] w);
        int bad_start = 0;
        int bad_busy  = 0;
        int bad_hold  = 0;
        int bad_pulse = 0;
        for (int k = 1; k <= P; k++) begin
            if (k > 1) @(negedge clk);
            if (start_transmit !== (k <= H)) bad_start++;
            if (busy !== (k < P)) bad_busy++;
            if (data !== w) bad_hold++;
            if (k < P && selector_cs !== 3'(ch)) bad_hold++;
            if (k > 1 && ack !== 4'd0) bad_pulse++;
            if (k < P && done !== 4'd0) bad_pulse++;
        end
        chk("start_window", 64'(bad_start), 0);
        chk("busy_window", 64'(bad_busy), 0);
        chk("sel_data_hold", 64'(bad_hold), 0);
        chk("stray_pulses", 64'(bad_pulse), 0);
        chk("done_pulse", 64'(done), 64'(4'b0001 << ch));
        chk("done_sel_idle", 64'(selector_cs), 64'd7);
    endtask

    initial begin
        int ch;
        int w;
        int seen;
        int order [5];
        int gaps [5];

        vecs[0] = '{4'b0100, {10'h0, 10'h2A5, 10'h0, 10'h0}, 2, 10'h2A5};
        vecs[1] = '{4'b0001, STD, 0, 10'h1F0};
        vecs[2] = '{4'b1010, STD, 1, 10'h0AA};
        vecs[3] = '{4'b1000, STD, 3, 10'h3C3};
        vecs[4] = '{4'b0110, STD, 1, 10'h0AA};
        vecs[5] = '{4'b1111, STD, 0, 10'h1F0};

        reset = 1'b1;
        enable = 1'b1;
        req = 4'd0;
        req_data = 40'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outputs",
            64'({start_transmit, selector_cs, data, ack, done, busy}),
            64'({1'b0, 3'd7, 10'd0, 4'd0, 4'd0, 1'b0}));
        @(posedge clk);
        #1 reset = 1'b0;

        for (int v = 0; v < 6; v++) begin
            do_reset();
            req = vecs[v].req;
            req_data = vecs[v].rdata;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("v%0d_ack", v), 64'(ack),
                64'(4'b0001 << vecs[v].exp_ch));
            chk($sformatf("v%0d_sel", v), 64'(selector_cs),
                64'(vecs[v].exp_ch));
            chk($sformatf("v%0d_data", v), 64'(data),
                64'(vecs[v].exp_data));
            req = 4'd0;
            req_data = 40'd0;
            run_frame(vecs[v].exp_ch, vecs[v].exp_data);
        end

        do_reset();
        req_data = STD;
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_ack(ch, w);
            order[g] = ch;
            gaps[g] = w;
        end
        req = 4'd0;
        chk("rr_order",
            64'({order[0][3:0], order[1][3:0], order[2][3:0],
                 order[3][3:0], order[4][3:0]}),
            64'({4'd0, 4'd1, 4'd2, 4'd3, 4'd0}));
        chk("rr_spacing",
            64'({gaps[1][7:0], gaps[2][7:0], gaps[3][7:0], gaps[4][7:0]}),
            64'({8'(P), 8'(P), 8'(P), 8'(P)}));
        wait_done(ch);
        chk("rr_last_done", 64'(ch), 64'(0));

        do_reset();
        req = 4'b0010;
        wait_ack(ch, w);
        chk("wrap_first", 64'(ch), 64'(1));
        req = 4'd0;
        wait_done(ch);
        chk("wrap_first_done", 64'(ch), 64'(1));
        req = 4'b0011;
        wait_ack(ch, w);
        chk("wrap_next", 64'(ch), 64'(0));
        chk("wrap_next_lat", 64'(w), 64'(1));
        req = 4'd0;
        wait_done(ch);

        do_reset();
        req = 4'b1000;
        wait_ack(ch, w);
        chk("abort_grant", 64'(ch), 64'(3));
        req = 4'd0;
        repeat (20) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_outputs",
            64'({start_transmit, selector_cs, busy, done, ack}),
            64'({1'b0, 3'd7, 1'b0, 4'd0, 4'd0}));
        reset = 1'b0;
        seen = 0;
        repeat (P + 5) begin
            @(negedge clk);
            if (done != 4'd0 || busy) seen++;
        end
        chk("abort_no_done", 64'(seen), 64'(0));
        req = 4'b1000;
        wait_ack(ch, w);
        chk("abort_regrant", 64'(ch), 64'(3));
        chk("abort_regrant_data", 64'(data), 64'(10'h3C3));
        req = 4'd0;
        wait_done(ch);
        chk("abort_regrant_done", 64'(ch), 64'(3));

        do_reset();
        enable = 1'b0;
        req = 4'b0001;
        seen = 0;
        repeat (100) begin
            @(negedge clk);
            if (ack != 4'd0 || busy) seen++;
        end
        chk("disable_no_ack", 64'(seen), 64'(0));
        enable = 1'b1;
        @(negedge clk);
        chk("enable_ack", 64'(ack), 64'(4'b0001));
        req = 4'd0;
        enable = 1'b0;
        wait_done(ch);
        chk("enable_frame_done", 64'(ch), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_tx_arbiter.md
Name: spi_tx_arbiter

Overview:
Round-robin scheduler that shares one SPI_TX master among four 10-bit requesters (one per chip-select line).
- Captures a requester's word and drives selector_cs, data and a start_transmit pulse into the master.
- The master gives no completion signal, so the block times each frame with a fixed-length window.
- It then holds the selector through a guard gap, so the selected sep_cs line latches CS high before the selector is released.
- Sits between the frame-register logic and SPI_TX.

Parameters:
START_HOLD, 4, cycles start_transmit stays high per frame (must be ≥2 and <FRAME_CYCLES).
FRAME_CYCLES, 16500, cycles from start assertion until the master is guaranteed back in IDLE with its internal start flag cleared (must exceed master frame length ~16 030 and its 2500-cycle flag window).
GAP_CYCLES, 16, guard cycles with selector held and start low after the frame window (≥2).
CNT_W, 16, timer width (2^CNT_W > FRAME_CYCLES + GAP_CYCLES).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  1 = grants allowed; 0 = no new grant, an in-flight frame completes
req  in  4  level request per channel; held until ack
req_data  in  40  channel n word on bits [10n+9:10n]
ack  out  4  one-cycle pulse: channel word captured
done  out  4  one-cycle pulse: channel frame finished
busy  out  1  frame in progress
start_transmit  out  1  to SPI_TX start_transmit
selector_cs  out  3  to SPI_TX selector_cs; 3'd7 = no channel
data  out  10  to SPI_TX data, stable for the whole frame

Behaviour:
- Reset values:
  - start_transmit=0, selector_cs=3'd7, data=0, ack=0, done=0, busy=0.
  - Round-robin pointer: channel 0 highest priority.
  - State=IDLE, timer=0.
- States:
  - IDLE → START on edge E0 if enable=1 and req≠0.
  - START: START_HOLD cycles.
  - WAIT: until timer reaches FRAME_CYCLES.
  - GAP: GAP_CYCLES cycles.
  - DONE: 1 cycle, then IDLE.
- Arbitration at E0:
  - Winner = first asserted req scanning upward (mod 4) from last_grant+1.
  - Register data ← req_data word of the winner, selector_cs ← winner index.
  - ack[winner]=1 for exactly the cycle after E0; pointer ← winner.
- Cycle numbering: cycle k = k-th cycle after E0.
  - start_transmit=1 in cycles 1..START_HOLD; 0 otherwise.
  - busy=1 in cycles 1..FRAME_CYCLES+GAP_CYCLES.
  - selector_cs and data are constant over cycles 1..FRAME_CYCLES+GAP_CYCLES.
- Timer:
  - Starts at 1 in cycle 1 and increments every cycle.
  - WAIT ends when timer=FRAME_CYCLES; GAP ends when timer=FRAME_CYCLES+GAP_CYCLES.
- Cycle FRAME_CYCLES+GAP_CYCLES+1 (DONE):
  - done[winner]=1, busy=0, selector_cs=3'd7.
  - data holds its last value.
  - The earliest next grant is at the edge ending this cycle, so back-to-back frame period = FRAME_CYCLES+GAP_CYCLES+1.
- Requests:
  - Only sampled in IDLE; deassertion before grant means the channel is not served.
  - req changes during a frame have no effect on data/selector.
  - A requester may reassert immediately after ack.
- enable=0: in-flight frame unaffected; FSM stays in IDLE with outputs at idle values.
- At most one bit of ack and at most one bit of done is set in any cycle.
- Reset mid-frame: all outputs return to reset values on the next edge, pointer resets, and no done is issued for the aborted frame.

Test Plan:
- req=4'b0100, req_data[29:20]=10'h2A5 → ack=4'b0100 in cycle 1; selector_cs=2, data=10'h2A5; start_transmit high cycles 1–4; done=4'b0100 in cycle 16517; selector_cs=7 in cycle 16517.
- req=4'b1111 held, reissued after each ack → grant order 0,1,2,3,0; grant spacing 16517 cycles.
- After channel 1 served, req=4'b0011 simultaneously → channel 0 granted next (pointer wraps from 1 through 2,3 to 0).
- reset=1 asserted at cycle 8000 of a channel-3 frame → next cycle: start=0, selector_cs=7, busy=0, no done; a subsequent req=4'b1000 is granted normally.
- enable=0 with req=4'b0001 → no ack for 100 cycles; enable=1 → ack=4'b0001 in the next cycle.
- Bench with SPI_TX instance, single grant of word 10'h3FF → exactly one 10-bit frame on sdi/out_spi_clk; sep_cs[selected]=1 again before selector_cs returns to 7.
